// File: rtl/gtp_init_sequencer.sv
// Reset sequencer for a GTPE2_COMMON PLL0 and the GTPE2_CHANNEL it feeds: PLL reset, lock wait,
// GT reset pulse, USERRDY, resetdone wait, with timeout-driven retries and recovery on lock loss.
module gtp_init_sequencer #(
  parameter int PLL_RST_CYCLES = 8,
  parameter int GT_RST_CYCLES  = 8,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pll0_lock,
  input  logic       txresetdone,
  input  logic       rxresetdone,
  output logic       pll0_reset,
  output logic       gttxreset,
  output logic       gtrxreset,
  output logic       txuserrdy,
  output logic       rxuserrdy,
  output logic       done,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_dbg
);

  localparam int MAX_AB  = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int CNT_MAX = (MAX_AB > GT_RST_CYCLES) ? MAX_AB : GT_RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
  localparam logic [CW-1:0] PLL_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] GT_LAST  = CW'(GT_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLL_RST  = 3'd1,
    S_PLL_WAIT = 3'd2,
    S_GT_RST   = 3'd3,
    S_GT_WAIT  = 3'd4,
    S_DONE     = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] counter, cnt_n;
  logic [3:0]    retry_n;
  logic          take_retry;
  logic          pll_rst_n, gt_rst_n, userrdy_n, done_n, fail_n;

  // Bit order {lock, txresetdone, rxresetdone}; only sync_q is used for decisions.
  logic [2:0] sync_meta, sync_q;
  logic       lock_s, txdone_s, rxdone_s;

  assign lock_s    = sync_q[2];
  assign txdone_s  = sync_q[1];
  assign rxdone_s  = sync_q[0];
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {pll0_lock, txresetdone, rxresetdone};
      sync_q    <= sync_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      counter    <= '0;
      retry_cnt  <= '0;
      pll0_reset <= 1'b1;
      gttxreset  <= 1'b1;
      gtrxreset  <= 1'b1;
      txuserrdy  <= 1'b0;
      rxuserrdy  <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      counter    <= cnt_n;
      retry_cnt  <= retry_n;
      pll0_reset <= pll_rst_n;
      gttxreset  <= gt_rst_n;
      gtrxreset  <= gt_rst_n;
      txuserrdy  <= userrdy_n;
      rxuserrdy  <= userrdy_n;
      done       <= done_n;
      fail       <= fail_n;
    end
  end

  always_comb begin
    state_n    = state;
    retry_n    = retry_cnt;
    cnt_n      = (counter == CNT_TOP) ? counter : counter + 1'b1;
    take_retry = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_PLL_RST;
          retry_n = '0;
        end
      end
      S_PLL_RST: begin
        if (counter == PLL_LAST) state_n = S_PLL_WAIT;
      end
      S_PLL_WAIT: begin
        if (lock_s)                    state_n    = S_GT_RST;
        else if (counter == TMO_LAST)  take_retry = 1'b1;
      end
      S_GT_RST: begin
        if (!lock_s)                   take_retry = 1'b1;
        else if (counter == GT_LAST)   state_n    = S_GT_WAIT;
      end
      S_GT_WAIT: begin
        // Lock loss outranks resetdone, which outranks the timeout.
        if (!lock_s)                   take_retry = 1'b1;
        else if (txdone_s && rxdone_s) state_n    = S_DONE;
        else if (counter == TMO_LAST)  take_retry = 1'b1;
      end
      S_DONE: begin
        if (!lock_s) begin
          state_n = S_PLL_RST;
          retry_n = '0;
        end
      end
      S_FAIL: begin
        if (start) begin
          state_n = S_PLL_RST;
          retry_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (take_retry) begin
      if (retry_cnt < MAX_R) begin
        retry_n = retry_cnt + 4'd1;
        state_n = S_PLL_RST;
      end else begin
        retry_n = MAX_R;
        state_n = S_FAIL;
      end
    end

    if (state_n != state) cnt_n = '0;

    // Outputs are decoded from the next state so they move on the same edge as the state.
    pll_rst_n = (state_n == S_IDLE) || (state_n == S_PLL_RST) || (state_n == S_FAIL);
    gt_rst_n  = (state_n == S_IDLE) || (state_n == S_PLL_RST) || (state_n == S_PLL_WAIT) ||
                (state_n == S_GT_RST) || (state_n == S_FAIL);
    userrdy_n = (state_n == S_GT_WAIT) || (state_n == S_DONE);
    done_n    = (state_n == S_DONE);
    fail_n    = (state_n == S_FAIL);
  end

endmodule

// File: tb/tb_gtp_init_sequencer.sv
// Directed bench for gtp_init_sequencer: three instances (default, retry-to-fail on PLL lock,
// retry-to-fail on resetdone) driven one after another with hand-computed expectations.
module tb_gtp_init_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_PLL_RST = 3'd1, ST_PLL_WAIT = 3'd2,
                         ST_GT_RST = 3'd3, ST_GT_WAIT = 3'd4, ST_DONE = 3'd5;

  // Instance a: defaults
  logic a_start = 0, a_lock = 0, a_txrd = 0, a_rxrd = 0;
  logic a_pll, a_gttx, a_gtrx, a_txu, a_rxu, a_done, a_fail;
  logic [3:0] a_retry;
  logic [2:0] a_state;
  // Instance b: LOCK_TIMEOUT=16, MAX_RETRIES=2, lock never arrives
  logic b_start = 0, b_lock = 0, b_txrd = 0, b_rxrd = 0;
  logic b_pll, b_gttx, b_gtrx, b_txu, b_rxu, b_done, b_fail;
  logic [3:0] b_retry;
  logic [2:0] b_state;
  // Instance c: LOCK_TIMEOUT=16, MAX_RETRIES=1, rxresetdone never arrives
  logic c_start = 0, c_lock = 1, c_txrd = 1, c_rxrd = 0;
  logic c_pll, c_gttx, c_gtrx, c_txu, c_rxu, c_done, c_fail;
  logic [3:0] c_retry;
  logic [2:0] c_state;

  gtp_init_sequencer dut_a (
    .clk(clk), .rst(rst), .start(a_start), .pll0_lock(a_lock), .txresetdone(a_txrd),
    .rxresetdone(a_rxrd), .pll0_reset(a_pll), .gttxreset(a_gttx), .gtrxreset(a_gtrx),
    .txuserrdy(a_txu), .rxuserrdy(a_rxu), .done(a_done), .fail(a_fail),
    .retry_cnt(a_retry), .state_dbg(a_state)
  );

  gtp_init_sequencer #(.LOCK_TIMEOUT(16), .MAX_RETRIES(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .pll0_lock(b_lock), .txresetdone(b_txrd),
    .rxresetdone(b_rxrd), .pll0_reset(b_pll), .gttxreset(b_gttx), .gtrxreset(b_gtrx),
    .txuserrdy(b_txu), .rxuserrdy(b_rxu), .done(b_done), .fail(b_fail),
    .retry_cnt(b_retry), .state_dbg(b_state)
  );

  gtp_init_sequencer #(.LOCK_TIMEOUT(16), .MAX_RETRIES(1)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .pll0_lock(c_lock), .txresetdone(c_txrd),
    .rxresetdone(c_rxrd), .pll0_reset(c_pll), .gttxreset(c_gttx), .gtrxreset(c_gtrx),
    .txuserrdy(c_txu), .rxuserrdy(c_rxu), .done(c_done), .fail(c_fail),
    .retry_cnt(c_retry), .state_dbg(c_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int run;
    int falls;
    int rises;
    logic prev;

    // ---- reset: 3 cycles ----
    #1;
    repeat (3) tick();
    check("rst_pll0_reset", 32'(a_pll), 1);
    check("rst_gt_resets", 32'({a_gttx, a_gtrx}), 3);
    check("rst_userrdy", 32'({a_txu, a_rxu}), 0);
    check("rst_done_fail", 32'({a_done, a_fail}), 0);
    check("rst_retry_cnt", 32'(a_retry), 0);
    check("rst_state", 32'(a_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // ---- test 1: nominal bring-up; edge 1 samples start, pll0_reset low after edge 9 ----
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n = 1;
    while (a_pll && n < 60) begin tick(); n++; end
    check("t1_pll_fall_edges", 32'(n), 9);
    check("t1_gt_still_reset", 32'({a_gttx, a_gtrx}), 3);

    // test 6a: start during PLL_WAIT is ignored
    repeat (5) tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("t6_pllwait_state", 32'(a_state), 32'(ST_PLL_WAIT));
    check("t6_pllwait_pll", 32'(a_pll), 0);
    check("t6_pllwait_retry", 32'(a_retry), 0);
    repeat (14) tick();

    // lock arrives: 2 sync edges + 1 state edge
    a_lock = 1'b1;
    n = 0;
    while (a_state != ST_GT_RST && n < 60) begin tick(); n++; end
    check("t1_lock_latency", 32'(n), 3);
    n = 0;
    while (a_gttx && n < 60) begin tick(); n++; end
    check("t1_gt_reset_cycles", 32'(n), 8);
    check("t1_gtrx_fall", 32'(a_gtrx), 0);
    check("t1_userrdy_up", 32'({a_txu, a_rxu}), 3);

    repeat (30) tick();
    a_txrd = 1'b1;
    a_rxrd = 1'b1;
    n = 0;
    while (!a_done && n < 60) begin tick(); n++; end
    check("t1_done_latency", 32'(n), 3);
    check("t1_retry_cnt", 32'(a_retry), 0);
    check("t1_fail_low", 32'(a_fail), 0);
    check("t1_pll_low", 32'(a_pll), 0);

    // test 6b: start in DONE is ignored
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    check("t6_done_state", 32'(a_state), 32'(ST_DONE));
    check("t6_done_held", 32'(a_done), 1);
    check("t6_done_retry", 32'(a_retry), 0);

    // ---- test 3: lock loss in DONE for 4 cycles ----
    a_lock = 1'b0;
    n = 0;
    while (a_done && n < 60) begin tick(); n++; end
    check("t3_done_fall_edges", 32'(n), 3);
    check("t3_state_pll_rst", 32'(a_state), 32'(ST_PLL_RST));
    check("t3_pll_reset_high", 32'(a_pll), 1);
    check("t3_userrdy_low", 32'({a_txu, a_rxu}), 0);
    tick();
    a_lock = 1'b1;
    n = 0;
    while (!a_done && n < 200) begin tick(); n++; end
    check("t3_done_returns", 32'(a_done), 1);
    check("t3_retry_cnt", 32'(a_retry), 0);

    // ---- test 5: rst for one cycle in GT_WAIT ----
    a_txrd = 1'b0;
    a_rxrd = 1'b0;
    a_lock = 1'b0;
    tick();
    a_lock = 1'b1;
    n = 0;
    while (a_state != ST_GT_WAIT && n < 100) begin tick(); n++; end
    check("t5_reach_gt_wait", 32'(a_state), 32'(ST_GT_WAIT));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_resets_high", 32'({a_pll, a_gttx, a_gtrx}), 7);
    check("t5_userrdy_low", 32'({a_txu, a_rxu}), 0);
    check("t5_done_fail_low", 32'({a_done, a_fail}), 0);
    check("t5_state_idle", 32'(a_state), 32'(ST_IDLE));
    repeat (10) tick();
    check("t5_stays_idle", 32'(a_state), 32'(ST_IDLE));
    check("t5_pll_held", 32'(a_pll), 1);

    // ---- test 2: lock never arrives, 3 PLL0 pulses of 8 cycles, then FAIL ----
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    run = 1;
    falls = 0;
    rises = 0;
    prev = b_pll;
    n = 0;
    while (!b_fail && n < 500) begin
      tick();
      n++;
      if (prev && !b_pll) begin
        falls++;
        check("t2_pll_pulse_len", 32'(run), 8);
        run = 0;
      end else if (!prev && b_pll) begin
        rises++;
        check("t2_pll_wait_len", 32'(run), 16);
        run = 0;
      end
      run++;
      prev = b_pll;
    end
    check("t2_pulse_count", 32'(falls), 3);
    check("t2_timeouts", 32'(rises), 3);
    check("t2_fail", 32'({b_fail, b_done}), 2);
    check("t2_retry_cnt", 32'(b_retry), 2);
    check("t2_resets_high", 32'({b_pll, b_gttx, b_gtrx}), 7);
    check("t2_userrdy_low", 32'({b_txu, b_rxu}), 0);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("t2_restart_state", 32'(b_state), 32'(ST_PLL_RST));
    check("t2_restart_retry", 32'(b_retry), 0);
    check("t2_restart_fail", 32'(b_fail), 0);

    // ---- test 4: rxresetdone never arrives, GT_WAIT times out twice ----
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    run = 0;
    falls = 0;
    prev = c_txu;
    n = 0;
    while (!c_fail && n < 500) begin
      tick();
      n++;
      if (c_txu) run++;
      if (prev && !c_txu) begin
        falls++;
        check("t4_gt_wait_len", 32'(run), 16);
        run = 0;
      end
      prev = c_txu;
    end
    check("t4_timeouts", 32'(falls), 2);
    check("t4_fail", 32'({c_fail, c_done}), 2);
    check("t4_retry_cnt", 32'(c_retry), 1);
    check("t4_userrdy_low", 32'({c_txu, c_rxu}), 0);
    check("t4_resets_high", 32'({c_pll, c_gttx, c_gtrx}), 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
